// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/retire stage: exception codes and
// trace record sizing.
package wb_pkg;

    localparam int DEFAULT_EXC_W = 5;

    typedef enum logic [DEFAULT_EXC_W-1:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } excode_e;

    // A trace record is {pc, byte write enables, register number, write data}.
    function automatic int trace_width(input int data_w, input int dest_w);
        return 32 + data_w / 8 + dest_w + data_w;
    endfunction

endpackage

// File: rtl/wb_retire_stage_if.sv
// Memory-stage to writeback-stage instruction bus with its valid/allowin handshake.
interface wb_retire_stage_if #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 5,
    parameter int EXC_W  = wb_pkg::DEFAULT_EXC_W
);
    logic                ms_to_ws_valid;
    logic                ws_allowin;
    logic [31:0]         ms_pc;
    logic [DATA_W-1:0]   ms_result;
    logic [DATA_W/8-1:0] ms_rf_we;
    logic [DEST_W-1:0]   ms_dest;
    logic                ms_ex;
    logic                ms_bd;
    logic                ms_eret;
    logic                ms_mtc0;
    logic                ms_mfc0;
    logic [EXC_W-1:0]    ms_excode;
    logic [7:0]          ms_c0_addr;

    modport master (
        output ms_to_ws_valid, ms_pc, ms_result, ms_rf_we, ms_dest, ms_ex, ms_bd,
               ms_eret, ms_mtc0, ms_mfc0, ms_excode, ms_c0_addr,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, ms_pc, ms_result, ms_rf_we, ms_dest, ms_ex, ms_bd,
               ms_eret, ms_mtc0, ms_mfc0, ms_excode, ms_c0_addr,
        output ws_allowin
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// Trace record FIFO: pointer + count, head entry presented combinationally
// from storage (zero while empty). Push while full is accepted when a pop frees a slot.
module wb_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: every signal gets its default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the count guards it and the head is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: one instruction register, regfile and CP0 drive in the
// retire cycle, and a trace FIFO whose back-pressure stalls retirement.
module wb_retire_stage
    import wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEST_W      = 5,
    parameter int EXC_W       = DEFAULT_EXC_W,
    parameter int TRACE_DEPTH = 4
) (
    input  logic                clk,
    input  logic                resetn,
    wb_retire_stage_if.slave    ms,
    output logic [DATA_W/8-1:0] rf_we,
    output logic [DEST_W-1:0]   rf_waddr,
    output logic [DATA_W-1:0]   rf_wdata,
    output logic [7:0]          c0_addr,
    input  logic [DATA_W-1:0]   c0_rdata,
    output logic                c0_we,
    output logic [DATA_W-1:0]   c0_wdata,
    output logic                c0_ex,
    output logic [EXC_W-1:0]    c0_excode,
    output logic                c0_bd,
    output logic [31:0]         c0_pc,
    output logic                c0_eret,
    output logic                ws_flush,
    output logic                trace_valid,
    input  logic                trace_ready,
    output logic [31:0]         trace_pc,
    output logic [DATA_W/8-1:0] trace_wen,
    output logic [DEST_W-1:0]   trace_wnum,
    output logic [DATA_W-1:0]   trace_wdata,
    output logic [31:0]         retired_cnt
);
    localparam int WEN_W   = DATA_W / 8;
    localparam int TRACE_W = trace_width(DATA_W, DEST_W);

    typedef struct packed {
        logic [31:0]       pc;
        logic [DATA_W-1:0] result;
        logic [WEN_W-1:0]  rf_we;
        logic [DEST_W-1:0] dest;
        logic              ex;
        logic              bd;
        logic              eret;
        logic              mtc0;
        logic              mfc0;
        logic [EXC_W-1:0]  excode;
        logic [7:0]        c0_addr;
    } ws_entry_t;

    ws_entry_t          ws_q, ws_d;
    logic               ws_valid_q, ws_valid_d;
    logic [31:0]        retired_cnt_q, retired_cnt_d;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [TRACE_W-1:0] trace_head;
    logic               ready_go, retire, normal_retire, rf_write;
    logic [DATA_W-1:0]  wr_data;

    // A pop in the same cycle frees the slot this retirement's record needs.
    assign trace_valid   = !fifo_empty;
    assign fifo_pop      = trace_valid && trace_ready;
    assign ready_go      = !fifo_full || fifo_pop;
    assign retire        = ws_valid_q && ready_go;
    assign ms.ws_allowin = !ws_valid_q || ready_go;
    assign normal_retire = retire && !ws_q.ex;
    assign rf_write      = normal_retire && !ws_q.eret;
    assign wr_data       = ws_q.mfc0 ? c0_rdata : ws_q.result;
    assign fifo_push     = rf_write && (|ws_q.rf_we);
    assign c0_addr       = ws_q.c0_addr;
    assign retired_cnt   = retired_cnt_q;
    assign {trace_pc, trace_wen, trace_wnum, trace_wdata} = trace_head;

    always_comb begin
        ws_valid_d    = ws_valid_q;
        ws_d          = ws_q;
        retired_cnt_d = retired_cnt_q;
        if (ms.ws_allowin) ws_valid_d = ms.ms_to_ws_valid;
        if (ms.ms_to_ws_valid && ms.ws_allowin) begin
            ws_d = '{pc: ms.ms_pc, result: ms.ms_result, rf_we: ms.ms_rf_we, dest: ms.ms_dest,
                     ex: ms.ms_ex, bd: ms.ms_bd, eret: ms.ms_eret, mtc0: ms.ms_mtc0,
                     mfc0: ms.ms_mfc0, excode: ms.ms_excode, c0_addr: ms.ms_c0_addr};
        end
        // Whatever was accepted alongside a flush is squashed.
        if (ws_flush) ws_valid_d = 1'b0;
        if (normal_retire) retired_cnt_d = retired_cnt_q + 32'd1;
    end

    always_comb begin
        rf_we     = '0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        c0_we     = 1'b0;
        c0_wdata  = '0;
        c0_ex     = 1'b0;
        c0_excode = '0;
        c0_bd     = 1'b0;
        c0_pc     = '0;
        c0_eret   = 1'b0;
        ws_flush  = 1'b0;
        if (rf_write) begin
            rf_we    = ws_q.rf_we;
            rf_waddr = ws_q.dest;
            rf_wdata = wr_data;
            c0_we    = ws_q.mtc0;
            c0_wdata = ws_q.mtc0 ? ws_q.result : '0;
        end
        if (retire && ws_q.ex) begin
            c0_ex     = 1'b1;
            c0_excode = ws_q.excode;
            c0_bd     = ws_q.bd;
            c0_pc     = ws_q.pc;
            ws_flush  = 1'b1;
        end
        if (normal_retire && ws_q.eret) begin
            c0_eret  = 1'b1;
            ws_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ws_valid_q    <= 1'b0;
            ws_q          <= '0;
            retired_cnt_q <= '0;
        end else begin
            ws_valid_q    <= ws_valid_d;
            ws_q          <= ws_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    wb_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data ({ws_q.pc, ws_q.rf_we, ws_q.dest, wr_data}),
        .pop       (fifo_pop),
        .head_data (trace_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_wb_retire_stage.sv
// Self-checking bench for wb_retire_stage: directed scenarios plus randomized
// traffic compared cycle by cycle against a queue-based reference model.
module tb_wb_retire_stage;
    import wb_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEST_W = 5;
    localparam int EXC_W  = 5;
    localparam int DEPTH  = 4;

    typedef logic [229:0] vec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [3:0]  we;
        logic [4:0]  dest;
        logic        ex, bd, eret, mtc0, mfc0;
        logic [4:0]  excode;
        logic [7:0]  c0a;
    } instr_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } rec_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [7:0]  c0_addr;
    logic [31:0] c0_rdata;
    logic        c0_we;
    logic [31:0] c0_wdata;
    logic        c0_ex;
    logic [4:0]  c0_excode;
    logic        c0_bd;
    logic [31:0] c0_pc;
    logic        c0_eret, ws_flush, trace_valid, trace_ready;
    logic [31:0] trace_pc;
    logic [3:0]  trace_wen;
    logic [4:0]  trace_wnum;
    logic [31:0] trace_wdata;
    logic [31:0] retired_cnt;

    always #5 clk = ~clk;

    wb_retire_stage_if #(.DATA_W(DATA_W), .DEST_W(DEST_W), .EXC_W(EXC_W)) ms_if ();

    wb_retire_stage #(
        .DATA_W(DATA_W), .DEST_W(DEST_W), .EXC_W(EXC_W), .TRACE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetn(resetn), .ms(ms_if.slave),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .c0_addr(c0_addr), .c0_rdata(c0_rdata), .c0_we(c0_we), .c0_wdata(c0_wdata),
        .c0_ex(c0_ex), .c0_excode(c0_excode), .c0_bd(c0_bd), .c0_pc(c0_pc),
        .c0_eret(c0_eret), .ws_flush(ws_flush),
        .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_pc(trace_pc),
        .trace_wen(trace_wen), .trace_wnum(trace_wnum), .trace_wdata(trace_wdata),
        .retired_cnt(retired_cnt)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: the stage register, the trace records waiting, the counter.
    logic        m_valid;
    instr_t      m_ins;
    rec_t        m_fifo[$];
    logic [31:0] m_cnt;
    logic        in_valid;
    instr_t      in_ins;

    logic        e_pop, e_retire, e_allowin, e_write, e_exc, e_eret, e_flush, e_tv;
    logic [31:0] e_data;
    rec_t        e_head;

    instr_t      feed_q[$];
    logic [31:0] got_pcs[$];
    int          n_ret;

    function automatic void model_reset();
        m_valid = 1'b0;
        m_ins   = '0;
        m_fifo.delete();
        m_cnt   = '0;
    endfunction

    function automatic void model_eval();
        e_tv      = (m_fifo.size() != 0);
        e_pop     = e_tv && trace_ready;
        e_retire  = m_valid && (m_fifo.size() < DEPTH || e_pop);
        e_allowin = !m_valid || e_retire;
        e_write   = e_retire && !m_ins.ex && !m_ins.eret;
        e_exc     = e_retire && m_ins.ex;
        e_eret    = e_retire && !m_ins.ex && m_ins.eret;
        e_flush   = e_exc || e_eret;
        e_data    = m_ins.mfc0 ? c0_rdata : m_ins.result;
        e_head    = e_tv ? m_fifo[0] : '0;
    endfunction

    function automatic void model_advance();
        logic acc;
        acc = in_valid && e_allowin;
        if (e_pop) void'(m_fifo.pop_front());
        if (e_write && m_ins.we != 4'h0)
            m_fifo.push_back('{pc: m_ins.pc, wen: m_ins.we, wnum: m_ins.dest, wdata: e_data});
        if (e_retire && !m_ins.ex) m_cnt = m_cnt + 32'd1;
        if (e_allowin) m_valid = in_valid;
        if (e_flush) m_valid = 1'b0;
        if (acc) m_ins = in_ins;
    endfunction

    function automatic vec_t exp_vec();
        logic wmt;
        wmt = e_write && m_ins.mtc0;
        return {e_allowin, e_write ? m_ins.we : 4'h0, e_write ? m_ins.dest : 5'h0,
                e_write ? e_data : 32'h0, m_ins.c0a, wmt, wmt ? m_ins.result : 32'h0,
                e_exc, e_exc ? m_ins.excode : 5'h0, e_exc & m_ins.bd, e_exc ? m_ins.pc : 32'h0,
                e_eret, e_flush, e_tv, e_head.pc, e_head.wen, e_head.wnum, e_head.wdata, m_cnt};
    endfunction

    function automatic vec_t dut_vec();
        return {ms_if.ws_allowin, rf_we, rf_waddr, rf_wdata, c0_addr, c0_we, c0_wdata,
                c0_ex, c0_excode, c0_bd, c0_pc, c0_eret, ws_flush, trace_valid,
                trace_pc, trace_wen, trace_wnum, trace_wdata, retired_cnt};
    endfunction

    function automatic instr_t alu(input logic [31:0] pc, input logic [4:0] dest,
                                   input logic [31:0] val);
        instr_t t;
        t        = '0;
        t.pc     = pc;
        t.result = val;
        t.we     = 4'hF;
        t.dest   = dest;
        return t;
    endfunction

    function automatic instr_t rand_ins();
        instr_t t;
        t.pc     = $urandom & 32'hFFFF_FFFC;
        t.result = $urandom;
        t.we     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
        t.dest   = 5'($urandom);
        t.ex     = ($urandom_range(0, 15) == 0);
        t.eret   = !t.ex && ($urandom_range(0, 15) == 0);
        t.bd     = 1'($urandom);
        t.mtc0   = ($urandom_range(0, 7) == 0);
        t.mfc0   = !t.mtc0 && ($urandom_range(0, 7) == 0);
        t.excode = 5'($urandom);
        t.c0a    = 8'($urandom);
        return t;
    endfunction

    task automatic drive(input logic v, input instr_t i);
        in_valid = v;
        in_ins   = i;
        ms_if.ms_to_ws_valid = v;
        ms_if.ms_pc      = i.pc;
        ms_if.ms_result  = i.result;
        ms_if.ms_rf_we   = i.we;
        ms_if.ms_dest    = i.dest;
        ms_if.ms_ex      = i.ex;
        ms_if.ms_bd      = i.bd;
        ms_if.ms_eret    = i.eret;
        ms_if.ms_mtc0    = i.mtc0;
        ms_if.ms_mfc0    = i.mfc0;
        ms_if.ms_excode  = i.excode;
        ms_if.ms_c0_addr = i.c0a;
    endtask

    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        model_eval();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    // Presents feed_q in order, holding each instruction until accepted; records retires and pops.
    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            logic acc;
            if (feed_q.size() > 0) drive(1'b1, feed_q[0]);
            else drive(1'b0, '0);
            sample();
            if (rf_we !== 4'h0) n_ret++;
            if (trace_valid && trace_ready) got_pcs.push_back(trace_pc);
            acc = (feed_q.size() > 0) && e_allowin;
            advance();
            if (acc) void'(feed_q.pop_front());
        end
    endtask

    task automatic drain();
        trace_ready = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (!m_valid && m_fifo.size() == 0 && feed_q.size() == 0) break;
            run_cycles(1);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_eval();
        n_assert++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected %h", dut_vec(), exp_vec());
        end
        n_assert++;
        if (ms_if.ws_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_allowin: got %b expected 1", ms_if.ws_allowin);
        end
        resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        instr_t ins[4];
        trace_ready = 1'b1;
        got_pcs.delete();
        for (int i = 0; i < 4; i++) ins[i] = alu(32'h100 + 32'(4 * i), 5'(i + 1), $urandom);
        for (int k = 0; k < 7; k++) begin
            if (k < 4) drive(1'b1, ins[k]);
            else drive(1'b0, '0);
            sample();
            if (k >= 1 && k <= 4) begin
                n_assert++;
                if (rf_we !== 4'hF || rf_waddr !== 5'(k) || rf_wdata !== ins[k-1].result) begin
                    n_fail++;
                    $display("FAIL b2b_write cycle %0d: got we=%h addr=%0d data=%h expected we=f addr=%0d data=%h",
                             k, rf_we, rf_waddr, rf_wdata, k, ins[k-1].result);
                end
            end
            if (trace_valid && trace_ready) got_pcs.push_back(trace_pc);
            advance();
        end
        n_assert++;
        if (retired_cnt !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_retired_cnt: got %0d expected 4", retired_cnt);
        end
        n_assert++;
        if (got_pcs.size() != 4) begin
            n_fail++;
            $display("FAIL b2b_trace_count: got %0d expected 4", got_pcs.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_assert++;
                if (got_pcs[i] !== ins[i].pc) begin
                    n_fail++;
                    $display("FAIL b2b_trace_order %0d: got %h expected %h", i, got_pcs[i], ins[i].pc);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] pcs[6];
        drain();
        trace_ready = 1'b0;
        n_ret = 0;
        got_pcs.delete();
        for (int i = 0; i < 6; i++) begin
            pcs[i] = 32'h1000 + 32'(4 * i);
            feed_q.push_back(alu(pcs[i], 5'(i + 8), $urandom));
        end
        run_cycles(10);
        n_assert++;
        if (n_ret != 4 || ms_if.ws_allowin !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold: got retires=%0d allowin=%b expected retires=4 allowin=0",
                     n_ret, ms_if.ws_allowin);
        end
        trace_ready = 1'b1;
        run_cycles(12);
        n_assert++;
        if (n_ret != 6 || got_pcs.size() != 6) begin
            n_fail++;
            $display("FAIL stall_release: got retires=%0d records=%0d expected 6 and 6",
                     n_ret, got_pcs.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_assert++;
                if (got_pcs[i] !== pcs[i]) begin
                    n_fail++;
                    $display("FAIL stall_record %0d: got %h expected %h", i, got_pcs[i], pcs[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        logic acc;
        drain();
        trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) feed_q.push_back(alu(32'h4000 + 32'(4 * i), 5'(i + 1), $urandom));
        run_cycles(8);
        trace_ready = 1'b1;
        drive(1'b1, feed_q[0]);
        sample();
        n_assert++;
        if (rf_we !== 4'hF || trace_valid !== 1'b1 || ms_if.ws_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_retire: got we=%h tv=%b allowin=%b expected f 1 1",
                     rf_we, trace_valid, ms_if.ws_allowin);
        end
        acc = e_allowin;
        advance();
        if (acc) void'(feed_q.pop_front());
        trace_ready = 1'b0;
        drive(1'b0, '0);
        sample();
        n_assert++;
        if (ms_if.ws_allowin !== 1'b0 || rf_we !== 4'h0) begin
            n_fail++;
            $display("FAIL full_pop_occupancy: got allowin=%b we=%h expected 0 0 (fifo still full)",
                     ms_if.ws_allowin, rf_we);
        end
        advance();
        drain();
    endtask

    task automatic test_exception();
        instr_t sys, er;
        drain();
        sys        = alu(32'hBFC0_0100, 5'd3, 32'h1234);
        sys.ex     = 1'b1;
        sys.bd     = 1'b1;
        sys.excode = EXC_SYS;
        drive(1'b1, sys);
        sample();
        advance();
        drive(1'b1, alu(32'h2000, 5'd7, 32'h55));
        sample();
        n_assert++;
        if (c0_ex !== 1'b1 || c0_excode !== 5'd8 || c0_bd !== 1'b1 || c0_pc !== 32'hBFC0_0100) begin
            n_fail++;
            $display("FAIL exc_report: got ex=%b code=%0d bd=%b pc=%h expected 1 8 1 bfc00100",
                     c0_ex, c0_excode, c0_bd, c0_pc);
        end
        n_assert++;
        if (rf_we !== 4'h0 || ws_flush !== 1'b1 || c0_we !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_side_effects: got rf_we=%h flush=%b c0_we=%b expected 0 1 0",
                     rf_we, ws_flush, c0_we);
        end
        advance();
        drive(1'b0, '0);
        sample();
        n_assert++;
        if (rf_we !== 4'h0 || ms_if.ws_allowin !== 1'b1 || retired_cnt !== m_cnt) begin
            n_fail++;
            $display("FAIL exc_discard: got rf_we=%h allowin=%b cnt=%0d expected 0 1 %0d",
                     rf_we, ms_if.ws_allowin, retired_cnt, m_cnt);
        end
        advance();
        er      = alu(32'h3100, 5'd9, 32'h77);
        er.eret = 1'b1;
        drive(1'b1, er);
        sample();
        advance();
        drive(1'b0, '0);
        sample();
        n_assert++;
        if (c0_eret !== 1'b1 || ws_flush !== 1'b1 || rf_we !== 4'h0 || c0_ex !== 1'b0) begin
            n_fail++;
            $display("FAIL eret_commit: got eret=%b flush=%b rf_we=%h ex=%b expected 1 1 0 0",
                     c0_eret, ws_flush, rf_we, c0_ex);
        end
        advance();
    endtask

    task automatic test_cp0();
        instr_t mf, mt_ex, mt;
        drain();
        c0_rdata = 32'h0040_FF01;
        mf       = alu(32'h3000, 5'd2, 32'hDEAD_BEEF);
        mf.mfc0  = 1'b1;
        mf.c0a   = 8'h60;
        mt_ex        = alu(32'h3004, 5'd0, 32'hCAFE_0001);
        mt_ex.we     = 4'h0;
        mt_ex.mtc0   = 1'b1;
        mt_ex.ex     = 1'b1;
        mt_ex.excode = EXC_RI;
        mt_ex.c0a    = 8'h60;
        mt       = alu(32'h3008, 5'd0, 32'hA5A5_5A5A);
        mt.we    = 4'h0;
        mt.mtc0  = 1'b1;
        mt.c0a   = 8'h61;
        drive(1'b1, mf);
        sample();
        advance();
        drive(1'b1, mt_ex);
        sample();
        n_assert++;
        if (rf_we !== 4'hF || rf_waddr !== 5'd2 || rf_wdata !== 32'h0040_FF01 || c0_addr !== 8'h60) begin
            n_fail++;
            $display("FAIL mfc0_write: got we=%h addr=%0d data=%h c0_addr=%h expected f 2 0040ff01 60",
                     rf_we, rf_waddr, rf_wdata, c0_addr);
        end
        advance();
        drive(1'b0, '0);
        sample();
        n_assert++;
        if (c0_we !== 1'b0 || c0_ex !== 1'b1) begin
            n_fail++;
            $display("FAIL mtc0_excepting: got c0_we=%b c0_ex=%b expected 0 1", c0_we, c0_ex);
        end
        advance();
        drive(1'b1, mt);
        sample();
        advance();
        drive(1'b0, '0);
        sample();
        n_assert++;
        if (c0_we !== 1'b1 || c0_wdata !== 32'hA5A5_5A5A || c0_addr !== 8'h61) begin
            n_fail++;
            $display("FAIL mtc0_write: got we=%b data=%h addr=%h expected 1 a5a55a5a 61",
                     c0_we, c0_wdata, c0_addr);
        end
        advance();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            trace_ready = (cyc % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            c0_rdata    = $urandom;
            drive($urandom_range(0, 9) < 7, rand_ins());
            sample();
            n_assert++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", cyc, dut_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        drain();
        trace_ready = 1'b0;
        for (int i = 0; i < 6; i++) feed_q.push_back(alu(32'h5000 + 32'(4 * i), 5'(i + 1), $urandom));
        run_cycles(8);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        n_assert++;
        if (ms_if.ws_allowin !== 1'b1 || trace_valid !== 1'b0 || retired_cnt !== 32'd0 || rf_we !== 4'h0) begin
            n_fail++;
            $display("FAIL async_reset: got allowin=%b tv=%b cnt=%0d rf_we=%h expected 1 0 0 0",
                     ms_if.ws_allowin, trace_valid, retired_cnt, rf_we);
        end
        model_reset();
        feed_q.delete();
        drive(1'b0, '0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        sample();
        n_assert++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL after_reset: got %h expected %h", dut_vec(), exp_vec());
        end
        advance();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn      = 1'b0;
        trace_ready = 1'b0;
        c0_rdata    = '0;
        n_ret       = 0;
        drive(1'b0, '0);
        model_reset();
        test_reset();
        test_back_to_back();
        test_stall();
        test_full_pop();
        test_exception();
        test_cp0();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_retire_stage.md
# wb_retire_stage

Parametrised writeback stage, successor to the current single-entry WB stage. Accepts one instruction per cycle from the memory stage, retires it to the register file, and drives the CP0 write/exception/ERET interface from the retire cycle. Debug trace leaves through a DEPTH-entry FIFO with a valid/ready handshake, so a slow trace consumer stalls retirement instead of losing records. Sits between mem_stage and the regfile/cp0_regfile; CP0 itself is external.

## Interface
- DATA_W, 32: result/register width; multiple of 8.
- DEST_W, 5: register-number width.
- EXC_W, 5: exception-code width.
- TRACE_DEPTH, 4: trace FIFO entries; power of two, >= 2.
- clk  in  1  sole clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ms_to_ws_valid  in  1  MS holds a valid instruction.
- ws_allowin  out  1  WS accepts this cycle.
- ms_pc  in  32  instruction PC.
- ms_result  in  DATA_W  ALU/load result; also mtc0 write data.
- ms_rf_we  in  DATA_W/8  per-byte register write enables.
- ms_dest  in  DEST_W  destination register.
- ms_ex, ms_bd, ms_eret, ms_mtc0, ms_mfc0  in  1 each  exception, delay-slot, eret, mtc0, mfc0 flags.
- ms_excode  in  EXC_W  exception code.
- ms_c0_addr  in  8  CP0 register select {rd, sel}.
- rf_we  out  DATA_W/8;  rf_waddr  out  DEST_W;  rf_wdata  out  DATA_W  regfile write port / forward bus.
- c0_addr  out  8;  c0_rdata  in  DATA_W  CP0 read (combinational in CP0).
- c0_we  out  1;  c0_wdata  out  DATA_W  mtc0 write.
- c0_ex  out  1;  c0_excode  out  EXC_W;  c0_bd  out  1;  c0_pc  out  32  exception report.
- c0_eret  out  1  ERET commit.
- ws_flush  out  1  pipeline flush (exception or eret retiring).
- trace_valid  out  1;  trace_ready  in  1  trace handshake.
- trace_pc  out  32;  trace_wen  out  DATA_W/8;  trace_wnum  out  DEST_W;  trace_wdata  out  DATA_W.
- retired_cnt  out  32  count of retired (non-excepting) instructions.

## Operation
- Single WS register (ws_valid + captured fields), loaded when ms_to_ws_valid && ws_allowin.
- retire = ws_valid && ws_ready_go; ws_ready_go = !fifo_full || (trace_valid && trace_ready).
- ws_allowin = !ws_valid || ws_ready_go.
- On retire, excepting (ex=1): c0_ex=1, c0_excode/bd/pc driven; rf_we=0, c0_we=0, no trace push; ws_flush=1.
- On retire, eret (ex=0): c0_eret=1, ws_flush=1; eret writes no register.
- On retire, normal: rf_we=ms_rf_we captured; rf_wdata = mfc0 ? c0_rdata : result; c0_we=mtc0; trace push iff rf_we != 0; retired_cnt += 1 (eret included), wraps modulo 2^32.
- All rf/c0/flush outputs are 0 whenever retire=0; c0_addr driven from WS register regardless.
- Flush: next cycle ws_valid=0; an instruction accepted in the flush cycle is discarded.
- Trace FIFO: push/pop same cycle when full is legal; pop = trace_valid && trace_ready; FIFO outputs are head-entry registers; unaffected by flush.

## Timing
- Reset: ws_valid=0, FIFO empty, retired_cnt=0; all outputs 0 except ws_allowin=1.
- Latency: MS handshake in cycle N -> retire/regfile write in N+1 (no stall) -> trace_valid in N+2.
- Full FIFO with trace_ready=0: ws_allowin=0 while ws_valid; WS holds; no outputs asserted.
- Reset asserted mid-operation: state clears immediately (asynchronous); pending trace records lost.

## Structure
- Package wb_pkg: EXC_W default, excode constants (INT, ADEL, ADES, SYS, BP, RI, OV), trace record packing function/width.
- Sub-module wb_trace_fifo (parametrised width/depth, pointer + count, full/empty) instantiated once.

## Test plan
- Back-to-back 4 ALU writes, trace_ready=1 -> rf_we=4'hF each cycle N+1..N+4, 4 trace records in order, retired_cnt=4.
- trace_ready=0, 6 writes, TRACE_DEPTH=4 -> 4 retire, ws_allowin=0; raise trace_ready -> remaining 2 retire, 6 records total, none duplicated.
- Excepting SYSCALL (excode 8, bd=1, pc 0xBFC00100) -> c0_ex=1, c0_excode=8, c0_bd=1, rf_we=0, ws_flush=1; following accepted instruction discarded.
- mfc0 r2, Status with c0_rdata=0x0040FF01 -> rf_waddr=2, rf_wdata=0x0040FF01; mtc0 with ex=1 -> c0_we=0.
- Full FIFO, simultaneous pop and retire -> retire proceeds, occupancy stays 4.
- resetn low mid-stall -> ws_valid=0, trace_valid=0, retired_cnt=0 same cycle.
